// File: rtl/uart_rx_if.sv
// Byte-level valid/ready channel from the UART receiver to its consumer.
// The receiver drives the master side and the consumer drives the slave side.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, samples the middle of each bit and
// presents bytes on a valid/ready channel, flagging framing errors and overruns.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master rx_bus,
    output logic      busy,
    output logic      frame_err,
    output logic      overrun
);

    localparam int HALF    = (CLKS_PER_BIT - 1) / 2;
    localparam int HALF_M1 = (HALF > 0) ? HALF - 1 : 0;
    localparam int CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W   = $clog2(9);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_M1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(7);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_sync1;
    logic              r_sync2;
    logic              w_rx_s;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [BIT_W-1:0]  r_bit;
    logic [BIT_W-1:0]  w_bit_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              w_tick;
    logic              w_load;
    logic              w_ovr;
    logic              w_ferr;
    logic [7:0]        r_data;
    logic              r_valid;
    logic              r_frame_err;
    logic              r_overrun;

    // Synchronisers idle high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;
    assign w_tick = (r_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
        end
    end

    // r_cnt holds (cycles since last sample point - 1), so a terminal count of
    // CLKS_PER_BIT-1 lands exactly one bit period after the previous sample.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_load       = 1'b0;
        w_ovr        = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = (HALF == 0) ? DATA : START;
                end
            end
            START: begin
                if (r_cnt == HALF_CNT) begin
                    w_cnt_next   = '0;
                    w_state_next = w_rx_s ? IDLE : DATA;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_cnt_next   = '0;
                    w_shift_next = {w_rx_s, r_shift[7:1]};
                    if (r_bit == LAST_BIT) begin
                        w_bit_next   = '0;
                        w_state_next = STOP;
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_state_next = IDLE;
                        if (!r_valid || rx_bus.rx_ready) begin
                            w_load = 1'b1;
                        end else begin
                            w_ovr = 1'b1;
                        end
                    end else begin
                        w_ferr       = 1'b1;
                        w_state_next = WAIT_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // A load on the accept cycle keeps rx_valid high for the new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= w_ovr;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_bus.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_bus.rx_data  = r_data;
    assign rx_bus.rx_valid = r_valid;
    assign busy            = (r_state != IDLE);
    assign frame_err       = r_frame_err;
    assign overrun         = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx at 16 and 1 clocks per bit; expected bytes
// and error counts come from a frame-level model built as stimulus is sent.
module tb_uart_rx;

    logic clk = 1'b0;
    logic rstN16, rstN1;
    logic rx16, rx1;
    logic rdy16, rdy1;
    logic busy16, ferr16, ovr16;
    logic busy1, ferr1, ovr1;

    uart_rx_if bus16 ();
    uart_rx_if bus1 ();

    assign bus16.rx_ready = rdy16;
    assign bus1.rx_ready  = rdy1;

    uart_rx #(.CLKS_PER_BIT(16)) dut16 (
        .clk(clk), .rst_n(rstN16), .rx(rx16), .rx_bus(bus16.master),
        .busy(busy16), .frame_err(ferr16), .overrun(ovr16)
    );

    uart_rx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rstN1), .rx(rx1), .rx_bus(bus1.master),
        .busy(busy1), .frame_err(ferr1), .overrun(ovr1)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int startCyc16 = 0;

    logic [7:0] acc16[$];
    logic [7:0] acc1[$];
    int vcnt16, firstV16, ferrCnt16, ovrCnt16, busyCnt16, lastBusy16;
    int vcnt1, ferrCnt1, ovrCnt1;

    always @(posedge clk) cyc++;

    // Observers sample on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (bus16.rx_valid && rdy16) acc16.push_back(bus16.rx_data);
        if (bus16.rx_valid) begin
            vcnt16++;
            if (firstV16 < 0) firstV16 = cyc;
        end
        if (ferr16) ferrCnt16++;
        if (ovr16) ovrCnt16++;
        if (busy16) begin
            busyCnt16++;
            lastBusy16 = cyc;
        end
        if (bus1.rx_valid && rdy1) acc1.push_back(bus1.rx_data);
        if (bus1.rx_valid) vcnt1++;
        if (ferr1) ferrCnt1++;
        if (ovr1) ovrCnt1++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear16();
        acc16.delete();
        vcnt16 = 0; firstV16 = -1; ferrCnt16 = 0; ovrCnt16 = 0;
        busyCnt16 = 0; lastBusy16 = -1;
    endtask

    task automatic clear1();
        acc1.delete();
        vcnt1 = 0; ferrCnt1 = 0; ovrCnt1 = 0;
    endtask

    task automatic drive16(input logic b, input int n);
        rx16 = b;
        repeat (n) step();
    endtask

    task automatic drive1(input logic b, input int n);
        rx1 = b;
        repeat (n) step();
    endtask

    task automatic send16(input logic [7:0] data, input logic stopBit);
        startCyc16 = cyc;
        drive16(1'b0, 16);
        for (int i = 0; i < 8; i++) drive16(data[i], 16);
        drive16(stopBit, 16);
    endtask

    task automatic send1(input logic [7:0] data);
        drive1(1'b0, 1);
        for (int i = 0; i < 8; i++) drive1(data[i], 1);
        drive1(1'b1, 1);
    endtask

    task automatic test_reset();
        tests++; if (bus16.rx_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_data16: got %h expected 00", bus16.rx_data); end
        tests++; if (bus16.rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid16: got %b expected 0", bus16.rx_valid); end
        tests++; if ({busy16, ferr16, ovr16} !== 3'b000) begin fails++; $display("[TB] FAIL reset_flags16: got %b expected 000", {busy16, ferr16, ovr16}); end
        tests++; if ({bus1.rx_valid, busy1, ferr1, ovr1} !== 4'b0000) begin fails++; $display("[TB] FAIL reset_flags1: got %b expected 0000", {bus1.rx_valid, busy1, ferr1, ovr1}); end
    endtask

    task automatic test_single_frame();
        rdy16 = 1'b1;
        clear16();
        send16(8'hA5, 1'b1);
        drive16(1'b1, 20);
        tests++; if (acc16.size() !== 1) begin fails++; $display("[TB] FAIL single_count: got %0d expected 1", acc16.size()); end
        else begin
            tests++; if (acc16[0] !== 8'hA5) begin fails++; $display("[TB] FAIL single_data: got %h expected a5", acc16[0]); end
        end
        tests++; if (vcnt16 !== 1) begin fails++; $display("[TB] FAIL single_valid_len: got %0d expected 1", vcnt16); end
        tests++; if (firstV16 - startCyc16 !== 154) begin fails++; $display("[TB] FAIL single_latency: got %0d expected 154", firstV16 - startCyc16); end
        tests++; if (ferrCnt16 + ovrCnt16 !== 0) begin fails++; $display("[TB] FAIL single_errors: got %0d expected 0", ferrCnt16 + ovrCnt16); end
    endtask

    task automatic test_glitch();
        clear16();
        drive16(1'b0, 4);
        drive16(1'b1, 30);
        tests++; if (busyCnt16 < 7 || busyCnt16 > 8) begin fails++; $display("[TB] FAIL glitch_busy: got %0d expected 7..8", busyCnt16); end
        tests++; if (vcnt16 + ferrCnt16 !== 0) begin fails++; $display("[TB] FAIL glitch_outputs: got %0d expected 0", vcnt16 + ferrCnt16); end
    endtask

    task automatic test_frame_error();
        int highCyc;
        clear16();
        send16(8'h3C, 1'b0);
        drive16(1'b0, 40);
        highCyc = cyc;
        drive16(1'b1, 10);
        tests++; if (ferrCnt16 !== 1) begin fails++; $display("[TB] FAIL ferr_pulses: got %0d expected 1", ferrCnt16); end
        tests++; if (vcnt16 !== 0) begin fails++; $display("[TB] FAIL ferr_valid: got %0d expected 0", vcnt16); end
        tests++; if (lastBusy16 - highCyc !== 2) begin fails++; $display("[TB] FAIL ferr_busy_tail: got %0d expected 2", lastBusy16 - highCyc); end
    endtask

    task automatic test_overrun();
        logic [7:0] first, second;
        first  = 8'($urandom_range(0, 255));
        second = 8'($urandom_range(0, 255));
        rdy16 = 1'b0;
        clear16();
        send16(first, 1'b1);
        send16(second, 1'b1);
        drive16(1'b1, 20);
        tests++; if (bus16.rx_valid !== 1'b1) begin fails++; $display("[TB] FAIL ovr_valid_held: got %b expected 1", bus16.rx_valid); end
        tests++; if (bus16.rx_data !== first) begin fails++; $display("[TB] FAIL ovr_data_held: got %h expected %h", bus16.rx_data, first); end
        tests++; if (ovrCnt16 !== 1) begin fails++; $display("[TB] FAIL ovr_pulses: got %0d expected 1", ovrCnt16); end
        rdy16 = 1'b1;
        step();
        rdy16 = 1'b0;
        drive16(1'b1, 3);
        tests++; if (acc16.size() !== 1 || acc16[0] !== first) begin fails++; $display("[TB] FAIL ovr_transfer: got %0d bytes expected 1 of %h", acc16.size(), first); end
        tests++; if (bus16.rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL ovr_valid_clear: got %b expected 0", bus16.rx_valid); end
    endtask

    task automatic test_abort_reset();
        logic [7:0] held;
        held = 8'($urandom_range(1, 255));
        rdy16 = 1'b0;
        clear16();
        send16(held, 1'b1);
        drive16(1'b1, 4);
        drive16(1'b0, 16);
        drive16(1'b1, 16);
        drive16(1'b0, 5);
        #2;
        rstN16 = 1'b0;
        #1;
        tests++; if ({bus16.rx_valid, bus16.rx_data} !== 9'h000) begin fails++; $display("[TB] FAIL abort_async_bus: got %h expected 000", {bus16.rx_valid, bus16.rx_data}); end
        tests++; if ({busy16, ferr16, ovr16} !== 3'b000) begin fails++; $display("[TB] FAIL abort_async_flags: got %b expected 000", {busy16, ferr16, ovr16}); end
        rx16 = 1'b1;
        rdy16 = 1'b1;
        step();
        rstN16 = 1'b1;
        drive16(1'b1, 20);
        clear16();
        send16(8'h81, 1'b1);
        drive16(1'b1, 20);
        tests++; if (acc16.size() !== 1 || acc16[0] !== 8'h81) begin fails++; $display("[TB] FAIL abort_next_frame: got %0d bytes expected single 81", acc16.size()); end
        tests++; if (ferrCnt16 + ovrCnt16 !== 0) begin fails++; $display("[TB] FAIL abort_errors: got %0d expected 0", ferrCnt16 + ovrCnt16); end
    endtask

    task automatic test_random_frames();
        logic [7:0] expQ[$];
        logic [7:0] data;
        logic [7:0] got;
        int ferrExp;
        logic bad;
        ferrExp = 0;
        rdy16 = 1'b1;
        clear16();
        for (int n = 0; n < 8; n++) begin
            data = 8'($urandom_range(0, 255));
            bad  = ($urandom_range(0, 3) == 0);
            send16(data, !bad);
            if (bad) begin
                drive16(1'b0, $urandom_range(0, 20));
                ferrExp++;
            end else begin
                expQ.push_back(data);
            end
            drive16(1'b1, $urandom_range(1, 12));
        end
        drive16(1'b1, 20);
        tests++; if (acc16.size() !== expQ.size()) begin fails++; $display("[TB] FAIL rand_count: got %0d expected %0d", acc16.size(), expQ.size()); end
        foreach (expQ[i]) begin
            got = (i < acc16.size()) ? acc16[i] : 8'hxx;
            tests++; if (got !== expQ[i]) begin fails++; $display("[TB] FAIL rand_byte%0d: got %h expected %h", i, got, expQ[i]); end
        end
        tests++; if (ferrCnt16 !== ferrExp) begin fails++; $display("[TB] FAIL rand_ferr: got %0d expected %0d", ferrCnt16, ferrExp); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] expQ[$];
        logic [7:0] got;
        expQ.push_back(8'h5A);
        expQ.push_back(8'hC3);
        for (int n = 0; n < 4; n++) expQ.push_back(8'($urandom_range(0, 255)));
        rdy1 = 1'b1;
        clear1();
        foreach (expQ[i]) send1(expQ[i]);
        drive1(1'b1, 10);
        tests++; if (acc1.size() !== expQ.size()) begin fails++; $display("[TB] FAIL b2b_count: got %0d expected %0d", acc1.size(), expQ.size()); end
        foreach (expQ[i]) begin
            got = (i < acc1.size()) ? acc1[i] : 8'hxx;
            tests++; if (got !== expQ[i]) begin fails++; $display("[TB] FAIL b2b_byte%0d: got %h expected %h", i, got, expQ[i]); end
        end
        tests++; if (vcnt1 !== expQ.size()) begin fails++; $display("[TB] FAIL b2b_valid_cycles: got %0d expected %0d", vcnt1, expQ.size()); end
        tests++; if (ferrCnt1 + ovrCnt1 !== 0) begin fails++; $display("[TB] FAIL b2b_errors: got %0d expected 0", ferrCnt1 + ovrCnt1); end
    endtask

    initial begin
        rstN16 = 1'b0;
        rstN1  = 1'b0;
        rx16   = 1'b1;
        rx1    = 1'b1;
        rdy16  = 1'b1;
        rdy1   = 1'b1;
        clear16();
        clear1();
        repeat (3) step();
        test_reset();
        rstN16 = 1'b1;
        rstN1  = 1'b1;
        repeat (3) step();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_abort_reset();
        test_random_frames();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
